mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data width of both sources and the output.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in0_valid / in1_valid  input  1  source 0 / source 1 has a beat.
REQ-005 Port: in0_data / in1_data  input  WIDTH  source 0 / source 1 beat data.
REQ-006 Port: in0_last / in1_last  input  1  beat is final of its packet.
REQ-007 Port: in0_ready / in1_ready  output  1  beat accepted this cycle (combinational).
REQ-008 Port: out_valid  output  1  output register holds a beat.
REQ-009 Port: out_data  output  WIDTH  registered muxed data.
REQ-010 Port: out_last  output  1  registered last flag.
REQ-011 Port: out_ready  input  1  downstream accepts the beat.
REQ-012 Port: selector  output  1  current owner index (0 = source 0, 1 = source 1), registered.

Function
REQ-013 A transfer occurs on a port when its valid and ready are both high at a rising edge.
REQ-014 FSM states: IDLE, OWN0, OWN1; selector = 1 only in OWN1, holds its last value in IDLE.
REQ-015 can_load = ~out_valid | out_ready; inN_ready = can_load & (owner is N, or IDLE and N wins arbitration); never both high in one cycle.
REQ-016 IDLE arbitration: if only one source is valid it wins; if both are valid, the source not granted most recently wins (round-robin pointer, reset value selects source 0).
REQ-017 IDLE -> OWNn when source n transfers a beat with last = 0; IDLE stays IDLE when the beat has last = 1 (single-beat packet), pointer still updates.
REQ-018 OWNn -> IDLE when source n transfers a beat with last = 1; otherwise stays OWNn; the other source's ready stays low for the whole packet, regardless of its valid.
REQ-019 Latency: an accepted beat appears on out_data/out_last with out_valid = 1 at the next edge (1 cycle); throughput is 1 beat/cycle when out_ready is held high.
REQ-020 Output register loads only on an input transfer; out_valid clears when out_ready = 1 and no new beat is loaded; it holds data stable while out_valid = 1 and out_ready = 0.
REQ-021 Simultaneous drain and load (out_valid = 1, out_ready = 1, input transfer) keeps out_valid = 1 with the new beat, no bubble.
REQ-022 Back-to-back packets: after a last beat is accepted from source n, the next edge re-arbitrates in IDLE; when both sources are valid, ownership alternates per packet.
REQ-023 A source dropping valid mid-packet leaves the FSM in OWNn and out_valid drains normally; no timeout.

Reset
REQ-024 With rst_n = 0 at a rising edge: state = IDLE, pointer favours source 0, out_valid = 0, out_last = 0, out_data = 0, selector = 0.
REQ-025 During reset both inN_ready are low; an in-flight packet is abandoned, and the first beat after reset is arbitrated as a new packet.

Configuration
REQ-026 Macro MUX_ARBITER_FIXED_PRIO_EN: when defined, IDLE arbitration always prefers source 0 and the round-robin pointer is omitted. When undefined, REQ-016 round-robin applies; packet locking (REQ-017/018) is identical in both builds.

Verification
REQ-027 Reset: rst_n = 0 for 2 cycles with both valids high -> in0_ready = in1_ready = 0, out_valid = 0, selector = 0.
REQ-028 Contention: both sources stream single-beat packets (last = 1), data 0xA0000000+i and 0xB0000000+i, out_ready = 1 -> outputs alternate A0,B0,A1,B1,... one per cycle (fixed-prio build: all A beats first).
REQ-029 Lock: source 1 sends 4-beat packet 0x11..0x14 while source 0 is valid throughout -> in0_ready = 0 until 0x14 is accepted, selector = 1 during the packet, then 0x00000000 from source 0 wins next.
REQ-030 Backpressure: out_ready = 0 for 5 cycles with out_valid = 1 -> out_data stable, both inN_ready = 0; on out_ready = 1 the next beat loads in the same edge with no bubble.
REQ-031 Mid-packet reset: rst_n = 0 for 1 cycle after beat 2 of 4 from source 0 -> state IDLE, out_valid = 0; source 1 is then granted immediately when it is valid.

Source files
------------

// File: rtl/mux_arbiter.sv
// mux_arbiter
//   Two-source packet multiplexer with a single registered output stage.
//   When the FSM is idle, it arbitrates between the two sources. The winner
//   of a multi-beat packet keeps the output until its last beat is accepted.
//
// Ports
//   clk                  sole clock, rising edge
//   rst_n                synchronous active-low reset
//   in0_valid/data/last  source 0 beat
//   in0_ready            source 0 beat accepted this cycle (combinational)
//   in1_valid/data/last  source 1 beat
//   in1_ready            source 1 beat accepted this cycle (combinational)
//   out_valid/data/last  registered output beat
//   out_ready            downstream accepts the output beat
//   selector             registered owner index (1 only while source 1 owns)
//
// Configuration
//   MUX_ARBITER_FIXED_PRIO_EN  defined: idle arbitration always prefers
//                              source 0 and no round-robin pointer exists.
//                              undefined: round-robin between the sources.

module mux_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             selector
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       can_load;
    logic       win1;
    logic       grant0;
    logic       grant1;
    logic       xfer0;
    logic       xfer1;
    logic       load;

`ifdef MUX_ARBITER_FIXED_PRIO_EN
    always_comb win1 = in1_valid & ~in0_valid;
`else
    // 1 = source 1 is preferred when both sources are valid in IDLE
    logic rr_ptr;

    always_comb win1 = in1_valid & (~in0_valid | rr_ptr);

    // Only IDLE grants start packets, so only IDLE transfers move the pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (state != OWN0 && state != OWN1) begin
            if (xfer0)
                rr_ptr <= 1'b1;
            else if (xfer1)
                rr_ptr <= 1'b0;
        end
    end
`endif

    always_comb begin
        can_load = ~out_valid | out_ready;
        grant0   = 1'b0;
        grant1   = 1'b0;
        case (state)
            OWN0:    grant0 = 1'b1;
            OWN1:    grant1 = 1'b1;
            default: begin
                grant1 = win1;
                grant0 = in0_valid & ~win1;
            end
        endcase
        // Readies are forced low while reset is asserted.
        in0_ready = rst_n & can_load & grant0;
        in1_ready = rst_n & can_load & grant1;
        xfer0     = in0_valid & in0_ready;
        xfer1     = in1_valid & in1_ready;
        load      = xfer0 | xfer1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OWN0: if (xfer0 && in0_last) state_nxt = IDLE;
            OWN1: if (xfer1 && in1_last) state_nxt = IDLE;
            default: begin
                // Single-beat packets (last = 1) leave the FSM in IDLE.
                if (xfer0 && !in0_last)
                    state_nxt = OWN0;
                else if (xfer1 && !in1_last)
                    state_nxt = OWN1;
                else
                    state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            selector <= 1'b0;
        end else begin
            state <= state_nxt;
            // When the FSM returns to IDLE, the selector keeps the last owner.
            if (state_nxt == OWN1)
                selector <= 1'b1;
            else if (state_nxt == OWN0)
                selector <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= xfer1 ? in1_data : in0_data;
            out_last  <= xfer1 ? in1_last : in0_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter
//   Self-checking bench for mux_arbiter. Each accepted input beat is pushed
//   to a scoreboard queue. Each output handshake pops the queue and compares
//   the output beat with the popped entry. The bench runs a cycle table for
//   lock and backpressure, plus sequences for reset, contention and a reset
//   in the middle of a packet.

module tb_mux_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_last;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_last;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             selector;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [WIDTH:0] sb_q[$];   // {last, data}

    typedef struct {
        logic        r;
        logic        v0;
        logic [31:0] d0;
        logic        l0;
        logic        v1;
        logic [31:0] d1;
        logic        l1;
        logic        ordy;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        chk_out;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ol;
        logic        e_sel;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .selector  (selector)
    );

    function automatic vec_t mk(
        input logic r, input logic v0, input logic [31:0] d0, input logic l0,
        input logic v1, input logic [31:0] d1, input logic l1, input logic ordy,
        input logic e_rdy0, input logic e_rdy1, input logic chk_out,
        input logic e_ov, input logic [31:0] e_od, input logic e_ol, input logic e_sel);
        vec_t v;
        v.r = r; v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.ordy = ordy;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.chk_out = chk_out;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_sel = e_sel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [WIDTH:0] e;
        forever begin
            @(negedge clk);
            checks++;
            if (in0_ready === 1'b1 && in1_ready === 1'b1) begin
                errors++;
                $display("FAIL both_ready: in0_ready=1 in1_ready=1 expected at most one high (t=%0t)", $time);
            end
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got beat %0h expected none (t=%0t)", out_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_beat", 64'({out_last, out_data}), 64'(e));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned i0;
        int unsigned i1;
        int unsigned cyc;
        logic x0;
        logic x1;

        rst_n     = 1'b0;
        in0_valid = 1'b1; in0_data = 32'h0000_00AA; in0_last = 1'b0;
        in1_valid = 1'b1; in1_data = 32'h0000_00BB; in1_last = 1'b0;
        out_ready = 1'b1;

        fork
            monitor();
        join_none

        // Reset held for 2 cycles with both sources valid.
        step();
        chk("rst1_rdy0", 64'(in0_ready), 64'd0);
        chk("rst1_rdy1", 64'(in1_ready), 64'd0);
        step();
        chk("rst2_rdy0", 64'(in0_ready), 64'd0);
        chk("rst2_rdy1", 64'(in1_ready), 64'd0);
        chk("rst2_ovalid", 64'(out_valid), 64'd0);
        chk("rst2_odata", 64'(out_data), 64'd0);
        chk("rst2_olast", 64'(out_last), 64'd0);
        chk("rst2_sel", 64'(selector), 64'd0);

        // Cycle table. Each row's expected registered outputs are the values
        // present before that row's clock edge.
        tbl[0]  = mk(0, 1, 32'h00, 0, 1, 32'h00, 0, 1,  0, 0,  0, 0, 32'h00, 0, 0);
        tbl[1]  = mk(1, 0, 32'h00, 0, 1, 32'h11, 0, 1,  0, 1,  1, 0, 32'h00, 0, 0);
        tbl[2]  = mk(1, 1, 32'h00, 1, 1, 32'h12, 0, 1,  0, 1,  1, 1, 32'h11, 0, 1);
        tbl[3]  = mk(1, 1, 32'h00, 1, 1, 32'h13, 0, 1,  0, 1,  1, 1, 32'h12, 0, 1);
        for (int k = 4; k <= 8; k++)
            tbl[k] = mk(1, 1, 32'h00, 1, 1, 32'h14, 1, 0,  0, 0,  1, 1, 32'h13, 0, 1);
        tbl[9]  = mk(1, 1, 32'h00, 1, 1, 32'h14, 1, 1,  0, 1,  1, 1, 32'h13, 0, 1);
        tbl[10] = mk(1, 1, 32'h00, 1, 1, 32'h15, 1, 1,  1, 0,  1, 1, 32'h14, 1, 1);
        tbl[11] = mk(1, 0, 32'h00, 0, 1, 32'h15, 1, 1,  0, 1,  1, 1, 32'h00, 1, 1);
        tbl[12] = mk(1, 0, 32'h00, 0, 0, 32'h00, 0, 1,  0, 0,  1, 1, 32'h15, 1, 1);
        tbl[13] = mk(1, 0, 32'h00, 0, 0, 32'h00, 0, 0,  0, 0,  1, 0, 32'h15, 1, 1);

        for (int k = 0; k < 14; k++) begin
            rst_n     = tbl[k].r;
            in0_valid = tbl[k].v0; in0_data = tbl[k].d0; in0_last = tbl[k].l0;
            in1_valid = tbl[k].v1; in1_data = tbl[k].d1; in1_last = tbl[k].l1;
            out_ready = tbl[k].ordy;
            #1;
            chk($sformatf("tbl%0d_rdy0", k), 64'(in0_ready), 64'(tbl[k].e_rdy0));
            chk($sformatf("tbl%0d_rdy1", k), 64'(in1_ready), 64'(tbl[k].e_rdy1));
            if (tbl[k].chk_out) begin
                chk($sformatf("tbl%0d_ovalid", k), 64'(out_valid), 64'(tbl[k].e_ov));
                chk($sformatf("tbl%0d_odata", k), 64'(out_data), 64'(tbl[k].e_od));
                chk($sformatf("tbl%0d_olast", k), 64'(out_last), 64'(tbl[k].e_ol));
                chk($sformatf("tbl%0d_sel", k), 64'(selector), 64'(tbl[k].e_sel));
            end
            if (tbl[k].r && tbl[k].v0 && tbl[k].e_rdy0)
                sb_q.push_back({tbl[k].l0, tbl[k].d0});
            if (tbl[k].r && tbl[k].v1 && tbl[k].e_rdy1)
                sb_q.push_back({tbl[k].l1, tbl[k].d1});
            step();
        end

        // Contention: both sources stream single-beat packets.
`ifdef MUX_ARBITER_FIXED_PRIO_EN
        for (int unsigned n = 0; n < 4; n++) sb_q.push_back({1'b1, 32'hA000_0000 + n});
        for (int unsigned n = 0; n < 4; n++) sb_q.push_back({1'b1, 32'hB000_0000 + n});
`else
        for (int unsigned n = 0; n < 4; n++) begin
            sb_q.push_back({1'b1, 32'hA000_0000 + n});
            sb_q.push_back({1'b1, 32'hB000_0000 + n});
        end
`endif
        i0 = 0; i1 = 0; cyc = 0;
        out_ready = 1'b1;
        while ((i0 < 4 || i1 < 4) && cyc < 30) begin
            in0_valid = (i0 < 4); in0_data = 32'hA000_0000 + i0; in0_last = 1'b1;
            in1_valid = (i1 < 4); in1_data = 32'hB000_0000 + i1; in1_last = 1'b1;
            @(negedge clk);
            x0 = in0_valid && in0_ready;
            x1 = in1_valid && in1_ready;
            step();
            i0 += x0 ? 1 : 0;
            i1 += x1 ? 1 : 0;
            cyc++;
        end
        chk("cont_cycles", 64'(cyc), 64'd8);
        in0_valid = 1'b0; in1_valid = 1'b0;
        repeat (3) step();
        chk("cont_drained", 64'(sb_q.size()), 64'd0);

        // Reset arrives after beat 2 of a 4-beat packet from source 0.
        in0_valid = 1'b1; in0_data = 32'hC000_0001; in0_last = 1'b0;
        #1;
        chk("mid_b1_rdy0", 64'(in0_ready), 64'd1);
        sb_q.push_back({1'b0, 32'hC000_0001});
        step();
        in0_data = 32'hC000_0002;
        #1;
        chk("mid_b2_rdy0", 64'(in0_ready), 64'd1);
        sb_q.push_back({1'b0, 32'hC000_0002});
        step();
        rst_n = 1'b0;
        in0_data = 32'hC000_0003;
        in1_valid = 1'b1; in1_data = 32'hD000_0001; in1_last = 1'b1;
        #1;
        chk("mid_rst_rdy0", 64'(in0_ready), 64'd0);
        chk("mid_rst_rdy1", 64'(in1_ready), 64'd0);
        step();
        rst_n = 1'b0;
        rst_n = 1'b1;
        // The beat that was in the output register is discarded by the reset.
        sb_q.delete();
        chk("mid_ovalid", 64'(out_valid), 64'd0);
        chk("mid_sel", 64'(selector), 64'd0);
        in0_valid = 1'b0;
        #1;
        chk("mid_new_rdy1", 64'(in1_ready), 64'd1);
        chk("mid_new_rdy0", 64'(in0_ready), 64'd0);
        sb_q.push_back({1'b1, 32'hD000_0001});
        step();
        in1_valid = 1'b0;
        chk("mid_out_valid", 64'(out_valid), 64'd1);
        chk("mid_out_data", 64'(out_data), 64'hD000_0001);
        repeat (3) step();
        chk("mid_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
